// File: rtl/lane_striper_pkg.sv
// Shared constants and types for the Aurora TX lane striper.
package lane_striper_pkg;

    // 8b/10b control characters sent with ctrl=1.
    localparam logic [7:0] K_A  = 8'h7C;  // /A/ align
    localparam logic [7:0] K_K  = 8'hBC;  // /K/ comma
    localparam logic [7:0] K_R  = 8'h1C;  // /R/ skip
    localparam logic [7:0] K_CC = 8'hFC;  // /K28.7/ clock compensation

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CC
    } striper_state_e;

    // Idle sequence position -> symbol: A,K,R,K repeating.
    function automatic logic [7:0] idle_symbol(input logic [1:0] cnt);
        if (cnt[0])
            return K_K;
        else if (cnt[1])
            return K_R;
        else
            return K_A;
    endfunction

endpackage

// File: rtl/lane_striper_if.sv
// AXI-Stream style word interface feeding the lane striper.
interface lane_striper_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;

    modport master (output s_tdata, output s_tvalid, input  s_tready);
    modport slave  (input  s_tdata, input  s_tvalid, output s_tready);
endinterface

// File: rtl/lane_striper_cc_scheduler.sv
// Clock-compensation scheduler: free-running period timer plus a sticky
// request that survives until the striper reaches a word boundary.
module cc_scheduler #(
    parameter int CC_PERIOD = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic link_up,
    input  logic cc_start,
    output logic cc_due
);
    localparam int TW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(CC_PERIOD - 1);

    logic [TW-1:0] cc_timer;
    logic          cc_pending;

    assign cc_due = (cc_timer == LAST) | cc_pending;

    // Timer counts only while the link is up; a wrap latches a pending
    // request unless the striper is starting a CC in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_timer   <= '0;
            cc_pending <= 1'b0;
        end else begin
            if (!link_up)
                cc_timer <= '0;
            else if (cc_timer == LAST)
                cc_timer <= '0;
            else
                cc_timer <= cc_timer + 1'b1;

            if (cc_start)
                cc_pending <= 1'b0;
            else if (link_up && cc_timer == LAST)
                cc_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/lane_striper.sv
// Aurora TX lane front-end: stripes AXI-Stream words byte-wise over
// 1/2/4/8 lanes, fills gaps with the A/K/R idle sequence and inserts
// periodic clock-compensation sequences between words.
module lane_striper
    import lane_striper_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LANES     = 4,
    parameter int CC_PERIOD = 5000,
    parameter int CC_LEN    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_up,
    input  logic [1:0]           lane_mode,
    lane_striper_if.slave        s_axis,
    output logic                 cc_active,
    output logic [LANES-1:0]     ctrl_out,
    output logic [LANES*8-1:0]   data_out
);
    localparam int BYTES   = DATA_W / 8;
    localparam int MAX_N   = (LANES < BYTES) ? LANES : BYTES;
    localparam int MAX_LOG = $clog2(MAX_N);
    localparam int BEAT_W  = $clog2(BYTES + 1);
    localparam int CNT_W   = $clog2(CC_LEN + 1);

    striper_state_e    state;
    logic [BEAT_W-1:0] beat;
    logic [CNT_W-1:0]  cc_cnt;
    logic [1:0]        idle_cnt;
    logic [1:0]        lane_mode_q;
    logic [DATA_W-1:0] word_q;

    logic cc_due, cc_start;
    logic boundary, last_beat, cc_last, ready, accept;
    logic [1:0] mode_clamped;

    striper_state_e    nxt_state;
    logic [BEAT_W-1:0] nxt_beat;
    logic [CNT_W-1:0]  nxt_cc_cnt;
    logic [DATA_W-1:0] nxt_word;
    logic [1:0]        nxt_mode;
    logic [1:0]        idle_base;
    logic [LANES-1:0]  nxt_ctrl;
    logic [LANES*8-1:0] nxt_data;
    logic              nxt_cc_active;

    // Byte idx of a word, counting from the MSB end.
    function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] w, input int idx);
        logic [DATA_W-1:0] s;
        s = w << (8 * idx);
        return s[DATA_W-1 -: 8];
    endfunction

    cc_scheduler #(.CC_PERIOD(CC_PERIOD)) u_cc (
        .clk      (clk),
        .rst      (rst),
        .link_up  (link_up),
        .cc_start (cc_start),
        .cc_due   (cc_due)
    );

    assign mode_clamped = (int'(lane_mode) > MAX_LOG) ? 2'(MAX_LOG) : lane_mode;
    assign last_beat    = (int'(beat) == (BYTES >> lane_mode_q) - 1);
    assign boundary     = (state == IDLE) | ((state == DATA) & last_beat);
    assign cc_last      = (state == CC) & (int'(cc_cnt) == CC_LEN - 1);
    assign ready        = !rst & link_up & !cc_due & (boundary | cc_last);
    assign accept       = ready & s_axis.s_tvalid;
    assign cc_start     = link_up & boundary & cc_due;
    assign s_axis.s_tready = ready;

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        nxt_state     = state;
        nxt_beat      = beat;
        nxt_cc_cnt    = cc_cnt;
        nxt_word      = word_q;
        nxt_mode      = boundary ? mode_clamped : lane_mode_q;
        idle_base     = (state == IDLE) ? idle_cnt : 2'd0;
        nxt_ctrl      = '1;
        nxt_data      = {LANES{K_K}};
        nxt_cc_active = 1'b0;

        if (!link_up) begin
            nxt_state  = IDLE;
            nxt_beat   = '0;
            nxt_cc_cnt = '0;
        end else begin
            unique case (state)
                IDLE, DATA: begin
                    if (boundary) begin
                        if (cc_due) begin
                            nxt_state  = CC;
                            nxt_cc_cnt = '0;
                        end else if (accept) begin
                            nxt_state = DATA;
                            nxt_beat  = '0;
                            nxt_word  = s_axis.s_tdata;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_beat = beat + 1'b1;
                    end
                end
                CC: begin
                    if (cc_last) begin
                        if (accept) begin
                            nxt_state = DATA;
                            nxt_beat  = '0;
                            nxt_word  = s_axis.s_tdata;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_cc_cnt = cc_cnt + 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase

            nxt_cc_active = (nxt_state == CC);
            for (int j = 0; j < LANES; j++) begin
                if (j < (1 << nxt_mode)) begin
                    unique case (nxt_state)
                        IDLE: nxt_data[8*j +: 8] = idle_symbol(idle_base);
                        DATA: begin
                            nxt_ctrl[j]          = 1'b0;
                            nxt_data[8*j +: 8]   = pick_byte(nxt_word, int'(nxt_beat) * (1 << nxt_mode) + j);
                        end
                        CC:   nxt_data[8*j +: 8] = K_CC;
                        default: nxt_data[8*j +: 8] = K_K;
                    endcase
                end
            end
        end
    end

    // Single registered FSM: state, counters, sampled lane mode and lane outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            cc_cnt      <= '0;
            idle_cnt    <= 2'd0;
            lane_mode_q <= 2'd0;
            ctrl_out    <= '1;
            data_out    <= {LANES{K_K}};
            cc_active   <= 1'b0;
        end else begin
            state       <= nxt_state;
            beat        <= nxt_beat;
            cc_cnt      <= nxt_cc_cnt;
            idle_cnt    <= (link_up && nxt_state == IDLE) ? idle_base + 2'd1 : 2'd0;
            lane_mode_q <= nxt_mode;
            ctrl_out    <= nxt_ctrl;
            data_out    <= nxt_data;
            cc_active   <= nxt_cc_active;
        end
    end

    // Payload holding register for the word being striped.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; it is only read in DATA, which always loads it first.
        word_q <= nxt_word;
    end

endmodule

// File: tb/tb_lane_striper.sv
// Randomized bench for lane_striper against a frame-queue reference model.
module tb_lane_striper;
    import lane_striper_pkg::*;

    localparam int DATA_W    = 32;
    localparam int LANES     = 4;
    localparam int CC_PERIOD = 16;
    localparam int CC_LEN    = 2;

    localparam int M_IDLE = 0;
    localparam int M_DATA = 1;
    localparam int M_CC   = 2;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] data;
        logic        cc;
        int          kind;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        link_up = 1'b0;
    logic [1:0]  lane_mode = 2'd0;
    logic        cc_active;
    logic [3:0]  ctrl_out;
    logic [31:0] data_out;

    lane_striper_if #(.DATA_W(DATA_W)) axis ();

    lane_striper #(
        .DATA_W(DATA_W), .LANES(LANES), .CC_PERIOD(CC_PERIOD), .CC_LEN(CC_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .link_up   (link_up),
        .lane_mode (lane_mode),
        .s_axis    (axis),
        .cc_active (cc_active),
        .ctrl_out  (ctrl_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int          m_timer;
    bit          m_pending;
    int          m_n;
    int          m_idle_pos;
    frame_t      m_cur;
    frame_t      fq[$];
    bit          exp_ready;
    bit          m_acc;
    logic [31:0] m_acc_word;

    // Driver state
    logic [31:0] words[$];
    bit          want_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
        else
            n_pass++;
    endtask

    function automatic frame_t k_frame();
        frame_t f;
        f.ctrl = 4'hF; f.data = {4{8'hBC}}; f.cc = 1'b0; f.kind = M_IDLE;
        return f;
    endfunction

    function automatic frame_t idle_frame(input int n, input int pos);
        frame_t f;
        logic [7:0] s;
        case (pos % 4)
            0: s = 8'h7C;
            2: s = 8'h1C;
            default: s = 8'hBC;
        endcase
        f = k_frame();
        for (int j = 0; j < n; j++) f.data[8*j +: 8] = s;
        return f;
    endfunction

    function automatic frame_t cc_frame(input int n);
        frame_t f;
        f = k_frame();
        f.cc = 1'b1; f.kind = M_CC;
        for (int j = 0; j < n; j++) f.data[8*j +: 8] = 8'hFC;
        return f;
    endfunction

    function automatic frame_t data_frame(input logic [31:0] w, input int n, input int k);
        frame_t f;
        int idx;
        f = k_frame();
        f.kind = M_DATA;
        for (int j = 0; j < n; j++) begin
            idx = k * n + j;
            f.ctrl[j] = 1'b0;
            f.data[8*j +: 8] = 8'((w >> (24 - 8 * idx)) & 32'hFF);
        end
        return f;
    endfunction

    function automatic bit model_due();
        return (m_timer == CC_PERIOD - 1) || m_pending;
    endfunction

    // Advance the reference by one clock using the inputs seen at this edge.
    task automatic model_advance();
        bit due, free, acc, at_bound, start_cc;
        int nl;
        m_acc = 1'b0;
        if (rst) begin
            m_timer = 0; m_pending = 1'b0; m_n = 1; m_idle_pos = 0;
            fq.delete(); m_cur = k_frame();
            return;
        end
        due  = model_due();
        free = (fq.size() == 0);
        acc  = link_up && !due && free && axis.s_tvalid;
        if (!link_up) begin
            fq.delete(); m_cur = k_frame(); m_idle_pos = 0; m_timer = 0;
            return;
        end
        at_bound = free && (m_cur.kind != M_CC);
        if (at_bound) begin
            nl = 1 << lane_mode;
            m_n = (nl > 4) ? 4 : nl;
        end
        start_cc = at_bound && due;
        if (start_cc) begin
            for (int i = 0; i < CC_LEN; i++) fq.push_back(cc_frame(m_n));
            m_pending = 1'b0;
        end else if (acc) begin
            for (int k = 0; k < 4 / m_n; k++) fq.push_back(data_frame(axis.s_tdata, m_n, k));
            m_acc = 1'b1;
            m_acc_word = axis.s_tdata;
            void'(words.pop_front());
        end
        if (m_timer == CC_PERIOD - 1) begin
            m_timer = 0;
            if (!start_cc) m_pending = 1'b1;
        end else begin
            m_timer++;
        end
        if (fq.size() > 0) begin
            m_cur = fq.pop_front();
            m_idle_pos = 0;
        end else begin
            m_cur = idle_frame(m_n, m_idle_pos);
            m_idle_pos++;
        end
    endtask

    task automatic drive();
        if (words.size() == 0) words.push_back($urandom);
        axis.s_tvalid = want_valid;
        axis.s_tdata  = words[0];
    endtask

    // One clock: compare at negedge, advance model at posedge, drive after.
    task automatic cycle();
        @(negedge clk);
        if (!rst) begin
            exp_ready = link_up && !model_due() && (fq.size() == 0);
            check("ctrl_out",  {28'd0, ctrl_out},  {28'd0, m_cur.ctrl});
            check("data_out",  data_out,           m_cur.data);
            check("cc_active", {31'd0, cc_active}, {31'd0, m_cur.cc});
            check("s_tready",  {31'd0, axis.s_tready}, {31'd0, exp_ready});
        end
        @(posedge clk);
        model_advance();
        #1;
        drive();
    endtask

    task automatic wait_accept(input logic [31:0] w, input string tag);
        int n;
        n = 0;
        while (!(m_acc && m_acc_word == w) && n < 60) begin
            cycle();
            n++;
        end
        check(tag, {31'd0, m_acc}, 32'd1);
    endtask

    initial begin
        axis.s_tvalid = 1'b0;
        axis.s_tdata  = '0;

        // Reset with link down
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl",   {28'd0, ctrl_out}, 32'h0000_000F);
        check("reset_data",   data_out, 32'hBCBC_BCBC);
        check("reset_tready", {31'd0, axis.s_tready}, 32'd0);
        check("reset_cc",     {31'd0, cc_active}, 32'd0);
        @(posedge clk);
        model_advance();
        #1;
        drive();
        repeat (2) cycle();

        // Link up, no traffic: idle sequence
        link_up = 1'b1;
        repeat (10) cycle();

        // 4-lane back-to-back words, long enough to see several CC slots
        lane_mode = 2'd2;
        words.delete();
        words.push_back(32'hDEADBEEF);
        want_valid = 1'b1;
        drive();
        repeat (50) cycle();
        want_valid = 1'b0;
        repeat (4) cycle();

        // 1-lane continuous words
        lane_mode = 2'd0;
        words.delete();
        words.push_back(32'h11223344);
        words.push_back(32'h55667788);
        want_valid = 1'b1;
        drive();
        repeat (12) cycle();
        want_valid = 1'b0;
        repeat (6) cycle();

        // Link drop mid-word
        words.delete();
        words.push_back(32'hAABBCCDD);
        want_valid = 1'b1;
        drive();
        wait_accept(32'hAABBCCDD, "accept_aabbccdd");
        want_valid = 1'b0;
        repeat (2) cycle();
        link_up = 1'b0;
        repeat (3) cycle();
        link_up = 1'b1;
        repeat (8) cycle();

        // Lane mode change mid-word
        lane_mode = 2'd0;
        words.delete();
        words.push_back(32'h0102_0304);
        words.push_back(32'hA1A2_A3A4);
        want_valid = 1'b1;
        drive();
        wait_accept(32'h0102_0304, "accept_mode_word");
        lane_mode = 2'd2;
        repeat (10) cycle();
        want_valid = 1'b0;
        repeat (4) cycle();

        // Randomized traffic, mode changes and occasional link drops
        for (int i = 0; i < 1500; i++) begin
            want_valid = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) lane_mode = 2'($urandom_range(3));
            if (link_up && $urandom_range(149) == 0) link_up = 1'b0;
            else if (!link_up && $urandom_range(2) == 0) link_up = 1'b1;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lane_striper.md
# lane_striper

Parametrised Aurora TX lane front-end. It accepts AXI-Stream words, stripes them byte-wise across 1, 2, 4 or 8 active lanes, and inserts the idle sequence (/A/, /K/, /R/) and periodic clock-compensation (/CC/) sequences. Output goes to the per-lane 8b/10b encoders. All rate adaptation is done with an s_tready handshake on the single clock; the block generates no derived clocks.

## Interface
- DATA_W, 32: AXI word width; multiple of 8.
- LANES, 4: physical lanes, power of two, 1..8.
- CC_PERIOD, 5000: clk cycles between CC requests.
- CC_LEN, 6: CC symbols per lane per CC sequence.

- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- link_up  in  1  channel up; low forces all lanes to /K/.
- lane_mode  in  2  active lanes N = 2**lane_mode; values with N > min(LANES, DATA_W/8) clamp to that maximum.
- s_tdata  in  DATA_W  input word.
- s_tvalid  in  1  word valid.
- s_tready  out  1  word accepted when s_tvalid & s_tready.
- cc_active  out  1  CC symbols on the lanes this cycle.
- ctrl_out  out  LANES  per-lane K-flag to encoder.
- data_out  out  LANES×8  per-lane byte to encoder.

## Operation
- States: IDLE, DATA, CC. Outputs are registered.
- Beats per word: B = DATA_W/(8·N). In beat k, lane j (j<N) carries byte index k·N+j, with ctrl=0. Byte 0 is s_tdata[DATA_W-1 -: 8] (MSB first).
- Lanes j ≥ N always emit ctrl=1, 0xBC (/K/).
- lane_mode is sampled into lane_mode_q only at a word boundary (state IDLE, or the last beat of DATA). Changes mid-word are ignored until that boundary.
- IDLE with link_up=1: active lanes emit idle symbols from idle_cnt (2-bit, cleared on entry to IDLE, +1 per idle cycle).
  - cnt==0 → /A/ 0x7C
  - odd cnt → /K/ 0xBC
  - cnt==2 → /R/ 0x1C
  - Resulting sequence: A,K,R,K,A,…
- link_up=0: all lanes emit /K/, s_tready=0, state is forced to IDLE, any in-flight word is discarded, and cc_timer is cleared.
- cc_timer runs while link_up=1 and wraps at CC_PERIOD-1.
  - cc_due = (cc_timer==CC_PERIOD-1) | cc_pending.
  - cc_pending is set when the timer wraps. A second wrap while it is still pending is a no-op.
- s_tready = link_up & !cc_due & (state==IDLE | (state==DATA & last beat)). It never depends on s_tvalid.
- At a word boundary:
  - If cc_due: enter CC next cycle and clear cc_pending.
  - Otherwise, if a word is accepted: go to DATA with beat 0 of that word.
  - Otherwise: go to IDLE.
- CC: for CC_LEN cycles, active lanes emit ctrl=1, 0xFC (/K28.7/) and cc_active=1. Then the block goes to IDLE, or straight to DATA if a word is accepted in the last CC cycle. s_tready is asserted in the last CC cycle only if cc_due is low.
- CC is never inserted inside a word. No word is lost, duplicated or reordered.

## Timing
- Reset values:
  - ctrl_out all 1, every data_out byte 0xBC.
  - s_tready=0, cc_active=0.
  - state IDLE, idle_cnt 0, cc_timer 0, cc_pending 0, lane_mode_q 0.
- Reset mid-word or mid-CC: the word or CC is abandoned; reset values apply on the next cycle.
- Latency: a word accepted in cycle t shows beat 0 on the outputs in cycle t+1.
- Throughput: one word per B cycles with no gaps. s_tready is high in the last beat of each word.
- The idle-to-data switch and the data-to-CC switch both take effect on the cycle after the boundary.

## Structure
- aurora_pkg additions:
  - Constants K_A=8'h7C, K_K=8'hBC, K_R=8'h1C, K_CC=8'hFC.
  - typedef striper_state_e {IDLE, DATA, CC}.
- Sub-module cc_scheduler holds cc_timer and cc_pending.
  - Inputs: clk, rst, link_up, cc_start.
  - Output: cc_due.
  - Parameter: CC_PERIOD.
- Beat counter, byte mux and idle_cnt stay in lane_striper.

## Test plan
Bench parameters: DATA_W=32, LANES=4, CC_PERIOD=16, CC_LEN=2.
- Reset with link_up=0 → ctrl_out=4'b1111, all bytes 0xBC, s_tready=0. After link_up=1 with no traffic, lanes 0-3 repeat 7C,BC,1C,BC.
- lane_mode=2, accept 0xDEADBEEF at cycle t → cycle t+1 lanes0-3 = DE,AD,BE,EF with ctrl=0000. Back-to-back words emit one word per cycle.
- lane_mode=0, words 0x11223344 and 0x55667788 valid continuously → lane0 carries 11,22,33,44,55,…; lanes1-3 carry BC with ctrl=1; s_tready is high only on the 4th beat.
- Continuous 4-lane traffic → every 16 cycles s_tready drops, two cycles of 0xFC appear on all lanes with cc_active=1, and the data sequence is intact.
- lane_mode=0, link_up dropped after beat 2 of 0xAABBCCDD → next cycle all lanes BC with s_tready=0. After link_up returns, idle restarts at /A/ and the word is not resumed.
- lane_mode changed from 0 to 2 during beat 1 → the remaining beats stay on lane0, and the next word goes out 4-lane.
